// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the inst_sequencer slice: inst bit map, idle word, FSM encodings.
// The optional single-step feature is selected with the INST_SEQ_STEP_EN macro.
package inst_sequencer_pkg;

  typedef logic [33:0] inst_t;

  localparam int IDX_ACC      = 33;
  localparam int IDX_CEN_P    = 32;
  localparam int IDX_WEN_P    = 31;
  localparam int IDX_AP_LO    = 20;
  localparam int IDX_CEN_X    = 19;
  localparam int IDX_WEN_X    = 18;
  localparam int IDX_AX_LO    = 7;
  localparam int IDX_OFIFO_RD = 6;
  localparam int IDX_IFIFO_WR = 5;
  localparam int IDX_IFIFO_RD = 4;
  localparam int IDX_L0_RD    = 3;
  localparam int IDX_L0_WR    = 2;
  localparam int IDX_EXEC     = 1;
  localparam int IDX_LOAD     = 0;

  localparam inst_t IDLE_INST = 34'h1_800C_0000;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_W_L0   = 4'd1;
  localparam logic [3:0] S_W_LOAD = 4'd2;
  localparam logic [3:0] S_W_GAP  = 4'd3;
  localparam logic [3:0] S_X_L0   = 4'd4;
  localparam logic [3:0] S_EXEC   = 4'd5;
  localparam logic [3:0] S_DRAIN  = 4'd6;
  localparam logic [3:0] S_ACC    = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;
  localparam logic [3:0] S_PAUSE  = 4'd9;

  // Square-grid side length, used to recover kernel and image widths from tap/pixel counts.
  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Host/core-facing bundle of the inst_sequencer; the sequencer itself uses the slave modport.
// INST_SEQ_STEP_EN adds the step input.
interface inst_sequencer_if;
  import inst_sequencer_pkg::*;

  logic       start;
  logic       valid;
`ifdef INST_SEQ_STEP_EN
  logic       step;
`endif
  inst_t      inst;
  logic       busy;
  logic       done;
  logic [3:0] kij_idx;

`ifdef INST_SEQ_STEP_EN
  modport master (output start, valid, step, input inst, busy, done, kij_idx);
  modport slave  (input start, valid, step, output inst, busy, done, kij_idx);
`else
  modport master (output start, valid, input inst, busy, done, kij_idx);
  modport slave  (input start, valid, output inst, busy, done, kij_idx);
`endif

endinterface

// File: rtl/inst_sequencer_addr_gen.sv
// Output-pixel/tap counters for the accumulation pass and the matching psum address.
// Address is produced for the counters' next value so the parent can register it with inst.
module inst_sequencer_addr_gen
  import inst_sequencer_pkg::*;
#(
  parameter int len_kij  = 9,
  parameter int len_nij  = 36,
  parameter int len_onij = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        advance,
  output logic        grp_end,
  output logic        last_grp,
  output logic        gap_nxt,
  output logic [10:0] addr_nxt
);

  localparam int ksz  = isqrt(len_kij);
  localparam int ni   = isqrt(len_nij);
  localparam int o_ni = ni - ksz + 1;

  localparam logic [7:0] K_LAST = 8'(len_kij);
  localparam logic [7:0] O_LAST = 8'(len_onij - 1);

  logic [7:0]  o_q, k_q, o_d, k_d;
  logic [10:0] o_w, k_w;

  // k == len_kij is the idle slot that closes each output-pixel group.
  always_comb begin
    o_d = o_q;
    k_d = k_q;
    if (clear) begin
      o_d = '0;
      k_d = '0;
    end else if (advance) begin
      if (k_q == K_LAST) begin
        k_d = '0;
        o_d = (o_q == O_LAST) ? 8'd0 : o_q + 8'd1;
      end else begin
        k_d = k_q + 8'd1;
      end
    end
    o_w      = 11'(o_d);
    k_w      = 11'(k_d);
    addr_nxt = k_w * 11'(len_nij)
             + (o_w / 11'(o_ni) + k_w / 11'(ksz)) * 11'(ni)
             + (o_w % 11'(o_ni) + k_w % 11'(ksz));
  end

  assign grp_end  = (k_q == K_LAST);
  assign last_grp = (o_q == O_LAST);
  assign gap_nxt  = (k_d == K_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_q <= '0;
      k_q <= '0;
    end else begin
      o_q <= o_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// Conv-layer instruction sequencer: per-tap weight load, activation stream, execute, drain, then accumulate.
// INST_SEQ_STEP_EN inserts a PAUSE state between phases, released by bus.step.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_kij  = 9,
  parameter int len_nij  = 36,
  parameter int len_onij = 16,
  parameter int W_BASE   = 36,
  parameter int LOAD_GAP = 16
) (
  input logic               clk,
  input logic               reset,
  inst_sequencer_if.slave   bus
);

  if (row < 1 || col < 1 || LOAD_GAP < 1 || len_kij < 1 || len_kij > 16 || len_nij < 2 ||
      W_BASE + len_kij * col > 2048 || len_kij * len_nij > 2048 || len_nij > 2047 ||
      isqrt(len_kij) ** 2 != len_kij || isqrt(len_nij) ** 2 != len_nij ||
      (isqrt(len_nij) - isqrt(len_kij) + 1) ** 2 != len_onij) begin : g_bad_params
    $error("inst_sequencer: parameters out of range for 11-bit addressing");
  end

  localparam logic [10:0] COL_A  = 11'(col);
  localparam logic [10:0] NIJ_A  = 11'(len_nij);
  localparam logic [10:0] GAP_A  = 11'(LOAD_GAP);
  localparam logic [10:0] WB_A   = 11'(W_BASE);
  localparam logic [3:0]  KIJ_LAST = 4'(len_kij - 1);

  logic [3:0]  state_q, state_d, nx;
  logic [10:0] cnt_q, cnt_d;
  logic [3:0]  kij_q, kij_d;
  logic        wr_q, wr_d;
  logic        enter, acc_clr, acc_adv;
  logic        grp_end, last_grp, gap_nxt;
  logic [10:0] acc_addr;
  inst_t       inst_q, word_d;
  logic        busy_q, done_q;
`ifdef INST_SEQ_STEP_EN
  logic [3:0]  resume_q, resume_d;
`endif

  // Next-state decode: registers describe the word on the bus now, *_d the word for next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 11'd1;
    kij_d   = kij_q;
    wr_d    = bus.valid;
    enter   = 1'b0;
    nx      = state_q;
    acc_adv = 1'b0;
    acc_clr = 1'b0;
`ifdef INST_SEQ_STEP_EN
    resume_d = resume_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          enter = 1'b1;
          nx    = S_W_L0;
          kij_d = '0;
        end
      end
      S_W_L0:   if (cnt_q == COL_A)         begin enter = 1'b1; nx = S_W_LOAD; end
      S_W_LOAD: if (cnt_q == COL_A - 11'd1) begin enter = 1'b1; nx = S_W_GAP;  end
      S_W_GAP:  if (cnt_q == GAP_A - 11'd1) begin enter = 1'b1; nx = S_X_L0;   end
      S_X_L0:   if (cnt_q == NIJ_A)         begin enter = 1'b1; nx = S_EXEC;   end
      S_EXEC:   if (cnt_q == NIJ_A - 11'd1) begin enter = 1'b1; nx = S_DRAIN;  end
      S_DRAIN: begin
        cnt_d = cnt_q;
        if (wr_q) begin
          if (cnt_q == NIJ_A - 11'd1) begin
            enter = 1'b1;
            if (kij_q == KIJ_LAST) begin
              nx    = S_ACC;
              kij_d = '0;
            end else begin
              nx    = S_W_L0;
              kij_d = kij_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      S_ACC: begin
        acc_adv = 1'b1;
        if (grp_end && last_grp) begin
          enter = 1'b1;
          nx    = S_FIN;
        end
      end
      S_FIN: begin enter = 1'b1; nx = S_IDLE; end
`ifdef INST_SEQ_STEP_EN
      S_PAUSE: begin
        cnt_d = cnt_q;
        if (bus.step) begin
          enter = 1'b1;
          nx    = resume_q;
        end
      end
`endif
      default: begin enter = 1'b1; nx = S_IDLE; end
    endcase
    if (enter) begin
`ifdef INST_SEQ_STEP_EN
      if (state_q != S_IDLE && state_q != S_PAUSE && state_q != S_FIN) begin
        state_d  = S_PAUSE;
        resume_d = nx;
      end else
`endif
      begin
        state_d = nx;
        cnt_d   = '0;
        acc_clr = (nx == S_ACC);
      end
    end
  end

  inst_sequencer_addr_gen #(
    .len_kij  (len_kij),
    .len_nij  (len_nij),
    .len_onij (len_onij)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (acc_clr),
    .advance  (acc_adv),
    .grp_end  (grp_end),
    .last_grp (last_grp),
    .gap_nxt  (gap_nxt),
    .addr_nxt (acc_addr)
  );

  // l0_wr trails each SRAM read by one cycle, hence the extra trailing cycle in the L0 phases.
  always_comb begin
    word_d = IDLE_INST;
    case (state_d)
      S_W_L0: begin
        if (cnt_d < COL_A) begin
          word_d[IDX_CEN_X]         = 1'b0;
          word_d[IDX_AX_LO +: 11]   = WB_A + 11'(kij_d) * COL_A + cnt_d;
        end
        word_d[IDX_L0_WR] = (cnt_d != 11'd0);
      end
      S_W_LOAD: begin
        word_d[IDX_L0_RD] = 1'b1;
        word_d[IDX_LOAD]  = 1'b1;
      end
      S_X_L0: begin
        if (cnt_d < NIJ_A) begin
          word_d[IDX_CEN_X]       = 1'b0;
          word_d[IDX_AX_LO +: 11] = cnt_d;
        end
        word_d[IDX_L0_WR] = (cnt_d != 11'd0);
      end
      S_EXEC: begin
        word_d[IDX_L0_RD] = 1'b1;
        word_d[IDX_EXEC]  = 1'b1;
      end
      S_DRAIN: begin
        if (wr_d) begin
          word_d[IDX_OFIFO_RD]    = 1'b1;
          word_d[IDX_CEN_P]       = 1'b0;
          word_d[IDX_WEN_P]       = 1'b0;
          word_d[IDX_AP_LO +: 11] = 11'(kij_d) * NIJ_A + cnt_d;
        end
      end
      S_ACC: begin
        if (!gap_nxt) begin
          word_d[IDX_ACC]         = 1'b1;
          word_d[IDX_CEN_P]       = 1'b0;
          word_d[IDX_AP_LO +: 11] = acc_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      wr_q    <= 1'b0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      wr_q    <= wr_d;
      inst_q  <= word_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_FIN);
      done_q  <= (state_d == S_FIN);
    end
  end

`ifdef INST_SEQ_STEP_EN
  always_ff @(posedge clk) begin
    if (reset) resume_q <= S_IDLE;
    else       resume_q <= resume_d;
  end
`endif

  assign bus.inst    = inst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.kij_idx = kij_q;

endmodule
